// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the fifo read-side blocks.
//   FIFO_DATA_W   : default fifo word width
//   drain_state_t : fifo_drain FSM encoding (IDLE=0, ACTIVE=1, HOLD=2)
//   ERR_*         : protocol error codes raised by fifo_drain
package fifo_pkg;

  localparam int FIFO_DATA_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } drain_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_STRAY    = 2'd1;  // read data with no read outstanding
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;  // push needed into a full skid

endpackage

// File: rtl/fifo_drain_skid_buf.sv
// skid_buf -- small circular buffer that catches fifo read data which cannot
// be delivered in the cycle it arrives.
//   clk, RESET_L : clock, asynchronous active-low reset
//   push         : write push_data at the tail (caller guarantees room, or a
//                  simultaneous pop)
//   pop          : drop the head entry (caller guarantees non-empty)
//   head_data    : current head entry, meaningful while empty=0
//   count        : occupancy 0..SKID_DEPTH
//   empty, full  : occupancy flags
// Push and pop on the same edge leave count unchanged and advance both ends.
module skid_buf
  #(
    parameter int DATA_W     = 6,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = 2
  )
  (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
  );

  localparam int              PTR_W    = $clog2(SKID_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SKID_DEPTH - 1);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(SKID_DEPTH));

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain -- read-side controller for one fifo instance.
// Issues fifo_rd while the fifo has data, downstream is not paused and the
// skid buffer has room for every word that could still land. Read data comes
// back one cycle after fifo_rd; it is delivered straight through when nothing
// is queued and downstream is open, otherwise it is parked in the skid buffer.
//
// Handshake: fifo_rd in cycle N returns fifo_valid/fifo_data in cycle N+1.
// valid_out=1 marks data_out as a delivered beat for exactly that cycle; there
// is no ready, dest_pause=1 stops both reading and delivering.
//
// Ports
//   clk, RESET_L : clock, asynchronous active-low reset
//   fifo_empty   : fifo empty flag (independent of fifo_rd)
//   fifo_valid   : fifo read data valid, one cycle after fifo_rd
//   fifo_data    : fifo read data
//   dest_pause   : downstream backpressure
//   fifo_rd      : read strobe (combinational)
//   data_out     : delivered word (registered, holds when no beat)
//   valid_out    : delivered-beat flag (registered)
//   err_rd       : one-cycle pulse on a dropped word (registered)
//   state_dbg    : current FSM state, for checkers
// Optional build macro FIFO_DRAIN_STATS_EN adds:
//   rd_count     : saturating count of valid_out beats
//   hold_cycles  : saturating count of cycles spent in HOLD
module fifo_drain
  import fifo_pkg::*;
  #(
    parameter int DATA_W     = FIFO_DATA_W,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_W      = 2
  )
  (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              fifo_empty,
    input  logic              fifo_valid,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              dest_pause,
    output logic              fifo_rd,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              err_rd,
    output logic [1:0]        state_dbg
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       hold_cycles
`endif
  );

  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(SKID_DEPTH);

  drain_state_t      state;
  logic              inflight;

  logic [DATA_W-1:0] skid_head;
  logic [CNT_W-1:0]  skid_cnt;
  logic              skid_empty;
  logic              skid_full;
  logic              skid_push;
  logic              skid_pop;

  logic              credit_ok;
  logic              word_in;
  logic              stray;
  logic              have_skid;
  logic              deliver;
  logic              need_push;
  logic              overflow;
  logic [DATA_W-1:0] out_word;
  logic [1:0]        err_code;

  skid_buf #(
    .DATA_W     (DATA_W),
    .SKID_DEPTH (SKID_DEPTH),
    .CNT_W      (CNT_W)
  ) u_skid (
    .clk       (clk),
    .RESET_L   (RESET_L),
    .push      (skid_push),
    .push_data (fifo_data),
    .pop       (skid_pop),
    .head_data (skid_head),
    .count     (skid_cnt),
    .empty     (skid_empty),
    .full      (skid_full)
  );

  // Credit: queued words plus the one possibly in flight must fit the skid,
  // so a pause arriving at any time can always park the returning word.
  assign credit_ok = ({1'b0, skid_cnt} + {{CNT_W{1'b0}}, inflight}) < DEPTH_L;
  assign fifo_rd   = ~fifo_empty & ~dest_pause & credit_ok & (state != HOLD);

  always_comb begin
    word_in   = fifo_valid & inflight;
    stray     = fifo_valid & ~inflight;
    have_skid = ~skid_empty;
    // Queued words always leave first; new data only bypasses an empty skid.
    skid_pop  = ~dest_pause & have_skid;
    deliver   = ~dest_pause & (have_skid | word_in);
    need_push = word_in & (dest_pause | have_skid);
    overflow  = need_push & skid_full & ~skid_pop;
    skid_push = need_push & ~overflow;
    out_word  = have_skid ? skid_head : fifo_data;
    err_code  = ERR_NONE;
    if (stray)         err_code = ERR_STRAY;
    else if (overflow) err_code = ERR_OVERFLOW;
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      err_rd    <= 1'b0;
    end else begin
      inflight  <= fifo_rd;
      valid_out <= deliver;
      if (deliver) data_out <= out_word;
      err_rd    <= (err_code != ERR_NONE);
      case (state)
        IDLE:    if (fifo_rd) state <= ACTIVE;
        ACTIVE: begin
          if (dest_pause)                             state <= HOLD;
          else if (skid_empty && !inflight && fifo_empty) state <= IDLE;
        end
        HOLD:    if (!dest_pause) state <= ACTIVE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      rd_count    <= '0;
      hold_cycles <= '0;
    end else begin
      // Counts beats as they are launched, so rd_count tracks valid_out.
      if (deliver && rd_count != 16'hFFFF)          rd_count    <= rd_count + 1'b1;
      if (state == HOLD && hold_cycles != 16'hFFFF) hold_cycles <= hold_cycles + 1'b1;
    end
  end
`endif

endmodule
